// File: rtl/uart_load_ctrl.sv
// Framed UART loader: sync byte, 16-bit word count, little-endian 32-bit words, optional XOR checksum.
// Define UART_LOAD_CHECKSUM_EN to require the trailing checksum byte.
module uart_load_ctrl #(
   parameter int          ADDR_W         = 14,
   parameter int          BASE_ADDR      = 0,
   parameter int          MAX_WORDS      = 16384,
   parameter int          TIMEOUT_CYCLES = 2_000_000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              load_en,
   input  logic              rx_done,
   input  logic [7:0]        rx_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [1:0]        err_code
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

   state_t            state_q, state_d;
   logic              rx_done_q;
   logic [15:0]       len_q, len_d;
   logic [15:0]       word_idx_q, word_idx_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [23:0]       shift_q, shift_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              load_done_q, load_done_d;
   logic              load_err_q, load_err_d;
   logic [1:0]        err_code_q, err_code_d;
`ifdef UART_LOAD_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   logic        byte_acc;
   logic        in_frame;
   logic [15:0] len_new;

   assign byte_acc = rx_done & ~rx_done_q;
   assign in_frame = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                     (state_q == DATA)   || (state_q == CSUM);
   assign len_new  = {rx_data, len_q[7:0]};

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      word_idx_d  = word_idx_q;
      byte_idx_d  = byte_idx_q;
      shift_d     = shift_q;
      tmo_d       = tmo_q;
      err_code_d  = err_code_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef UART_LOAD_CHECKSUM_EN
      csum_d      = csum_q;
`endif

      // An accepted byte always beats a timeout landing in the same cycle.
      if (in_frame) begin
         if (byte_acc) begin
            tmo_d = '0;
         end else if (tmo_q == TMO_LAST) begin
            state_d    = ERR;
            err_code_d = 2'b10;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (byte_acc && load_en && (rx_data == SYNC_BYTE)) begin
               state_d    = LEN_LO;
               err_code_d = 2'b00;
               tmo_d      = '0;
`ifdef UART_LOAD_CHECKSUM_EN
               csum_d     = 8'h00;
`endif
            end
         end
         LEN_LO: begin
            if (byte_acc) begin
               len_d[7:0] = rx_data;
`ifdef UART_LOAD_CHECKSUM_EN
               csum_d     = csum_q ^ rx_data;
`endif
               state_d    = LEN_HI;
            end
         end
         LEN_HI: begin
            if (byte_acc) begin
               len_d[15:8] = rx_data;
`ifdef UART_LOAD_CHECKSUM_EN
               csum_d      = csum_q ^ rx_data;
`endif
               if ({16'd0, len_new} > $unsigned(MAX_WORDS)) begin
                  state_d    = ERR;
                  err_code_d = 2'b01;
               end else if (len_new == 16'd0) begin
`ifdef UART_LOAD_CHECKSUM_EN
                  state_d = CSUM;
`else
                  state_d = DONE;
`endif
               end else begin
                  state_d    = DATA;
                  word_idx_d = 16'd0;
                  byte_idx_d = 2'd0;
               end
            end
         end
         DATA: begin
            if (byte_acc) begin
`ifdef UART_LOAD_CHECKSUM_EN
               csum_d     = csum_q ^ rx_data;
`endif
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = {rx_data, shift_q};
                  mem_addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx_q);
                  word_idx_d  = word_idx_q + 16'd1;
                  if ((word_idx_q + 16'd1) == len_q) begin
`ifdef UART_LOAD_CHECKSUM_EN
                     state_d = CSUM;
`else
                     state_d = DONE;
`endif
                  end
               end else begin
                  shift_d = {rx_data, shift_q[23:8]};
               end
            end
         end
`ifdef UART_LOAD_CHECKSUM_EN
         CSUM: begin
            if (byte_acc) begin
               if (rx_data == csum_q) begin
                  state_d = DONE;
               end else begin
                  state_d    = ERR;
                  err_code_d = 2'b11;
               end
            end
         end
`endif
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs follow the next state so hold drops together with the done/err pulse.
      cpu_hold_d  = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                    (state_d == DATA)   || (state_d == CSUM);
      load_done_d = (state_d == DONE);
      load_err_d  = (state_d == ERR);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         rx_done_q   <= 1'b0;
         len_q       <= '0;
         word_idx_q  <= '0;
         byte_idx_q  <= '0;
         shift_q     <= '0;
         tmo_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_hold_q  <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         err_code_q  <= '0;
`ifdef UART_LOAD_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rx_done_q   <= rx_done;
         len_q       <= len_d;
         word_idx_q  <= word_idx_d;
         byte_idx_q  <= byte_idx_d;
         shift_q     <= shift_d;
         tmo_q       <= tmo_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_hold_q  <= cpu_hold_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
         err_code_q  <= err_code_d;
`ifdef UART_LOAD_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_hold  = cpu_hold_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;
   assign err_code  = err_code_q;

endmodule
